// File: rtl/bch_dec_arb.sv
// bch_dec_arb: round-robin arbiter feeding one BCH decoder from two requesters and routing responses back.
// Define BCH_DEC_ARB_ERRCNT_EN to add per-requester saturating uncorrectable-error counters.
module bch_dec_arb #(
    parameter int pDataWidth  = 16,
    parameter int pCodeWidth  = 27,
    parameter int pDecLatency = 2,
    parameter int pCntWidth   = 8
) (
    input  logic                  clk,
    input  logic                  rst_x,
    input  logic                  i_enable,
    input  logic                  i_cnt_clr,
    input  logic                  i_req0_valid,
    input  logic [pCodeWidth-1:0] i_req0_code,
    output logic                  o_req0_ready,
    input  logic                  i_req1_valid,
    input  logic [pCodeWidth-1:0] i_req1_code,
    output logic                  o_req1_ready,
    output logic                  o_dec_enable,
    output logic                  o_dec_code_valid,
    output logic [pCodeWidth-1:0] o_dec_code,
    input  logic                  i_dec_data_valid,
    input  logic [pDataWidth-1:0] i_dec_data,
    input  logic                  i_dec_corrected,
    input  logic                  i_dec_detected,
    output logic [1:0]            o_rsp_valid,
    output logic [pDataWidth-1:0] o_rsp_data,
    output logic                  o_rsp_corrected,
    output logic                  o_rsp_detected,
`ifdef BCH_DEC_ARB_ERRCNT_EN
    output logic [pCntWidth-1:0]  o_err_cnt0,
    output logic [pCntWidth-1:0]  o_err_cnt1,
`endif
    output logic                  o_busy,
    output logic                  o_seq_err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t                 r_state;
    logic                   r_last;
    logic                   r_seq_err;
    logic [pDecLatency-1:0] r_tag_v;
    logic [pDecLatency-1:0] r_tag_id;
    logic                   w_run;
    logic                   w_xfer;
    logic                   w_tag_v;
    logic                   w_tag_id;
    logic                   w_pend;

    // Requester 1 wins contention only when requester 0 was served last.
    assign w_run            = r_state == RUN;
    assign o_req0_ready     = w_run && i_req0_valid && (!i_req1_valid || r_last);
    assign o_req1_ready     = w_run && i_req1_valid && (!i_req0_valid || !r_last);
    assign w_xfer           = o_req0_ready || o_req1_ready;
    assign o_dec_code_valid = w_xfer;
    assign o_dec_code       = o_req1_ready ? i_req1_code : i_req0_code;
    assign o_dec_enable     = r_state != IDLE;

    assign w_tag_v         = r_tag_v[pDecLatency-1];
    assign w_tag_id        = r_tag_id[pDecLatency-1];
    assign o_rsp_valid     = (i_dec_data_valid && w_tag_v) ? (w_tag_id ? 2'b10 : 2'b01) : 2'b00;
    assign o_rsp_data      = i_dec_data;
    assign o_rsp_corrected = i_dec_corrected;
    assign o_rsp_detected  = i_dec_detected;
    assign o_seq_err       = r_seq_err;
    assign o_busy          = o_dec_enable || |r_tag_v;

    // Tags still in flight after this cycle's output entry retires.
    assign w_pend = |(r_tag_v << 1);

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_seq_err <= 1'b0;
            r_tag_v   <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_v  <= pDecLatency'({r_tag_v, w_xfer});
            r_tag_id <= pDecLatency'({r_tag_id, o_req1_ready});
            if (w_xfer) r_last <= o_req1_ready;
            if (i_dec_data_valid != w_tag_v) r_seq_err <= 1'b1;
            case (r_state)
                IDLE:    if (i_enable) r_state <= RUN;
                RUN:     if (!i_enable) r_state <= DRAIN;
                DRAIN:   if (!w_pend) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BCH_DEC_ARB_ERRCNT_EN
    logic [pCntWidth-1:0] r_cnt0;
    logic [pCntWidth-1:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (!rst_x || i_cnt_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (o_rsp_valid[0] && i_dec_detected && !(&r_cnt0)) r_cnt0 <= r_cnt0 + 1'b1;
            if (o_rsp_valid[1] && i_dec_detected && !(&r_cnt1)) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign o_err_cnt0 = r_cnt0;
    assign o_err_cnt1 = r_cnt1;
`else
    logic w_unused;
    assign w_unused = i_cnt_clr;
`endif
endmodule

// File: tb/tb_bch_dec_arb.sv
// tb_bch_dec_arb: directed and randomized checks of bch_dec_arb against a transaction-level model.
module tb_bch_dec_arb;
    localparam int DW  = 16;
    localparam int CW  = 27;
    localparam int LAT = 2;
    localparam int NW  = 2;

    logic          clk = 1'b0;
    logic          rst_x;
    logic          i_enable;
    logic          i_cnt_clr;
    logic          i_req0_valid;
    logic [CW-1:0] i_req0_code;
    logic          o_req0_ready;
    logic          i_req1_valid;
    logic [CW-1:0] i_req1_code;
    logic          o_req1_ready;
    logic          o_dec_enable;
    logic          o_dec_code_valid;
    logic [CW-1:0] o_dec_code;
    logic          i_dec_data_valid;
    logic [DW-1:0] i_dec_data;
    logic          i_dec_corrected;
    logic          i_dec_detected;
    logic [1:0]    o_rsp_valid;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_corrected;
    logic          o_rsp_detected;
`ifdef BCH_DEC_ARB_ERRCNT_EN
    logic [NW-1:0] o_err_cnt0;
    logic [NW-1:0] o_err_cnt1;
`endif
    logic          o_busy;
    logic          o_seq_err;

    bch_dec_arb #(
        .pDataWidth (DW),
        .pCodeWidth (CW),
        .pDecLatency(LAT),
        .pCntWidth  (NW)
    ) dut (
        .clk             (clk),
        .rst_x           (rst_x),
        .i_enable        (i_enable),
        .i_cnt_clr       (i_cnt_clr),
        .i_req0_valid    (i_req0_valid),
        .i_req0_code     (i_req0_code),
        .o_req0_ready    (o_req0_ready),
        .i_req1_valid    (i_req1_valid),
        .i_req1_code     (i_req1_code),
        .o_req1_ready    (o_req1_ready),
        .o_dec_enable    (o_dec_enable),
        .o_dec_code_valid(o_dec_code_valid),
        .o_dec_code      (o_dec_code),
        .i_dec_data_valid(i_dec_data_valid),
        .i_dec_data      (i_dec_data),
        .i_dec_corrected (i_dec_corrected),
        .i_dec_detected  (i_dec_detected),
        .o_rsp_valid     (o_rsp_valid),
        .o_rsp_data      (o_rsp_data),
        .o_rsp_corrected (o_rsp_corrected),
        .o_rsp_detected  (o_rsp_detected),
`ifdef BCH_DEC_ARB_ERRCNT_EN
        .o_err_cnt0      (o_err_cnt0),
        .o_err_cnt1      (o_err_cnt1),
`endif
        .o_busy          (o_busy),
        .o_seq_err       (o_seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int due;
    } tag_t;

    tag_t          exp_q[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            m_last = 1;
    logic [1:0]    m_pend = 2'b00;
    logic [CW-1:0] m_code [2] = '{'0, '0};
    bit            m_seq = 1'b0;
    bit            inj = 1'b0;
    bit            force_det = 1'b0;
    bit            force_clr = 1'b0;
    bit            rnd_clr = 1'b1;
`ifdef BCH_DEC_ARB_ERRCNT_EN
    int            m_cnt [2] = '{0, 0};
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req0_ready"}, o_req0_ready, 0);
        chk({tag, "_req1_ready"}, o_req1_ready, 0);
        chk({tag, "_dec_enable"}, o_dec_enable, 0);
        chk({tag, "_rsp_valid"}, o_rsp_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_seq_err"}, o_seq_err, 0);
`ifdef BCH_DEC_ARB_ERRCNT_EN
        chk({tag, "_err_cnt0"}, o_err_cnt0, 0);
        chk({tag, "_err_cnt1"}, o_err_cnt1, 0);
`endif
    endtask

    // One clock cycle; st is the arbiter phase the model expects: 0 idle, 1 run, 2 drain.
    task automatic run_cycle(input logic [1:0] newreq, input int st);
        int g;
        int id;
        bit due;
        due = 1'b0;
        id  = 0;
        for (int n = 0; n < 2; n++)
            if (newreq[n] && !m_pend[n]) begin
                m_pend[n] = 1'b1;
                m_code[n] = CW'($urandom);
            end
        if (exp_q.size() != 0)
            if (exp_q[0].due == cyc) begin
                due = 1'b1;
                id  = exp_q[0].id;
            end
        i_req0_valid     = m_pend[0];
        i_req0_code      = m_code[0];
        i_req1_valid     = m_pend[1];
        i_req1_code      = m_code[1];
        i_dec_data_valid = due || inj;
        i_dec_data       = DW'($urandom);
        i_dec_corrected  = 1'($urandom);
        i_dec_detected   = force_det || ($urandom_range(1) == 1);
        i_cnt_clr        = force_clr || (rnd_clr && $urandom_range(15) == 0);
        #1;
        chk("seq_err", o_seq_err, m_seq);
`ifdef BCH_DEC_ARB_ERRCNT_EN
        chk("err_cnt0", o_err_cnt0, m_cnt[0]);
        chk("err_cnt1", o_err_cnt1, m_cnt[1]);
`endif
        g = -1;
        if (st == 1) begin
            if (m_pend == 2'b11) g = 1 - m_last;
            else if (m_pend[0]) g = 0;
            else if (m_pend[1]) g = 1;
        end
        chk("req0_ready", o_req0_ready, g == 0);
        chk("req1_ready", o_req1_ready, g == 1);
        chk("dec_code_valid", o_dec_code_valid, g >= 0);
        if (g >= 0) chk("dec_code", o_dec_code, m_code[g]);
        chk("dec_enable", o_dec_enable, st != 0);
        chk("busy", o_busy, st != 0 || exp_q.size() != 0);
        chk("rsp_valid", o_rsp_valid, due ? (id == 1 ? 2 : 1) : 0);
        if (due) begin
            chk("rsp_data", o_rsp_data, i_dec_data);
            chk("rsp_corrected", o_rsp_corrected, i_dec_corrected);
            chk("rsp_detected", o_rsp_detected, i_dec_detected);
        end
        if (i_dec_data_valid != due) m_seq = 1'b1;
`ifdef BCH_DEC_ARB_ERRCNT_EN
        for (int n = 0; n < 2; n++)
            if (i_cnt_clr) m_cnt[n] = 0;
            else if (due && id == n && i_dec_detected && m_cnt[n] < (1 << NW) - 1) m_cnt[n]++;
`endif
        if (due) void'(exp_q.pop_front());
        if (g >= 0) begin
            exp_q.push_back('{g, cyc + LAT});
            m_pend[g] = 1'b0;
            m_last    = g;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic flush();
        int k;
        k = 0;
        while ((m_pend != 0 || exp_q.size() != 0) && k < 20) begin
            run_cycle(2'b00, 1);
            k++;
        end
        chk("flush_timeout", k < 20, 1);
    endtask

    initial begin
        rst_x            = 1'b0;
        i_enable         = 1'b1;
        i_cnt_clr        = 1'b0;
        i_req0_valid     = 1'b1;
        i_req0_code      = '0;
        i_req1_valid     = 1'b1;
        i_req1_code      = '0;
        i_dec_data_valid = 1'b0;
        i_dec_data       = '0;
        i_dec_corrected  = 1'b0;
        i_dec_detected   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst_x    = 1'b1;
        i_enable = 1'b0;
        run_cycle(2'b00, 0);
        i_enable = 1'b1;
        run_cycle(2'b00, 0);

        // Contention from a fresh reset: grants 0,1,0,1.
        repeat (4) run_cycle(2'b11, 1);
        flush();

        // Single requester with a fixed code.
        m_pend[0] = 1'b1;
        m_code[0] = 27'h5A5A5A5;
        run_cycle(2'b00, 1);
        flush();

        repeat (300) run_cycle(2'($urandom), 1);
        flush();

        // Drain: enable drops the cycle after a transfer.
        run_cycle(2'b01, 1);
        i_enable = 1'b0;
        run_cycle(2'b00, 1);
        run_cycle(2'b10, 2);
        run_cycle(2'b00, 0);
        m_pend = 2'b00;
        run_cycle(2'b00, 0);

        // Decoder data valid with nothing in flight.
        inj = 1'b1;
        run_cycle(2'b00, 0);
        inj = 1'b0;
        repeat (3) run_cycle(2'b00, 0);
        chk("t4_seq_sticky", o_seq_err, 1);

        // Reset with two transfers in flight.
        i_enable = 1'b1;
        run_cycle(2'b00, 0);
        run_cycle(2'b11, 1);
        run_cycle(2'b11, 1);
        rst_x            = 1'b0;
        i_enable         = 1'b0;
        i_dec_data_valid = 1'b0;
        m_pend           = 2'b00;
        @(posedge clk);
        #1;
        rst_x = 1'b1;
        cyc++;
        exp_q.delete();
        m_last = 1;
        m_seq  = 1'b0;
`ifdef BCH_DEC_ARB_ERRCNT_EN
        m_cnt = '{0, 0};
`endif
        check_reset("t5");
        repeat (4) run_cycle(2'b00, 0);

`ifdef BCH_DEC_ARB_ERRCNT_EN
        rnd_clr  = 1'b0;
        i_enable = 1'b1;
        run_cycle(2'b00, 0);
        force_det = 1'b1;
        repeat (5) run_cycle(2'b10, 1);
        flush();
        chk("t6_cnt1_sat", o_err_cnt1, 3);
        chk("t6_cnt0", o_err_cnt0, 0);
        run_cycle(2'b10, 1);
        run_cycle(2'b00, 1);
        force_clr = 1'b1;
        run_cycle(2'b00, 1);
        force_clr = 1'b0;
        force_det = 1'b0;
        chk("t6_clr_wins", o_err_cnt1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
